// File: rtl/constants_pkg.sv
// rtl/constants_pkg.sv - shared machine-wide constants for the multiply path
package constants_pkg;

    localparam int MUL_LATENCY = 5;
    localparam int ARCH_LEN    = 32;

endpackage

// File: rtl/instruction_pkg.sv
// rtl/instruction_pkg.sv - decoded instruction and multiply tracker slot types
package instruction_pkg;

    import constants_pkg::*;

    typedef struct packed {
        logic [4:0]          src_reg_1;
        logic [4:0]          src_reg_2;
        logic [4:0]          dst_reg;
        logic [ARCH_LEN-1:0] src_data_1;
        logic [ARCH_LEN-1:0] src_data_2;
        logic [ARCH_LEN-1:0] dst_reg_data;
    } inst_decoded_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } mul_slot_t;

    // x0 is hardwired, so it never participates in a hazard
    function automatic logic reg_hit(input logic [4:0] r, input logic [31:0] busy);
        return (r != 5'd0) && busy[r];
    endfunction

endpackage

// File: rtl/mul_issue_unit_if.sv
// rtl/mul_issue_unit_if.sv - issue, multiplier and writeback signals of the multiply issue unit
interface mul_issue_unit_if;

    import constants_pkg::*;
    import instruction_pkg::*;

    logic                in_valid;
    inst_decoded_t       inst_in;
    logic                in_ready;
    logic                flush;
    inst_decoded_t       inst_mul_in;
    logic                mul_issue;
    inst_decoded_t       inst_mul_out;
    logic                wb_valid;
    logic [4:0]          wb_rd;
    logic [ARCH_LEN-1:0] wb_data;
    logic [31:0]         busy_regs;

    modport master (
        output in_valid, inst_in, flush, inst_mul_out,
        input  in_ready, inst_mul_in, mul_issue, wb_valid, wb_rd, wb_data, busy_regs
    );

    modport slave (
        input  in_valid, inst_in, flush, inst_mul_out,
        output in_ready, inst_mul_in, mul_issue, wb_valid, wb_rd, wb_data, busy_regs
    );

endinterface

// File: rtl/mul_scoreboard.sv
// rtl/mul_scoreboard.sv - in-flight multiply tracker shift register and busy-register scoreboard
module mul_scoreboard
    import instruction_pkg::*;
#(
    parameter int LATENCY = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    output mul_slot_t   retire_slot,
    output logic [31:0] busy_regs
);

    mul_slot_t slots [LATENCY];

    // rd fields keep shifting on flush; only the valid bits are squashed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                slots[i] <= '0;
            end
        end else begin
            slots[0].valid <= issue && !flush;
            slots[0].rd    <= issue_rd;
            for (int i = 1; i < LATENCY; i++) begin
                slots[i].valid <= slots[i-1].valid && !flush;
                slots[i].rd    <= slots[i-1].rd;
            end
        end
    end

    always_comb begin
        busy_regs = '0;
        for (int i = 0; i < LATENCY; i++) begin
            if (slots[i].valid) begin
                busy_regs[slots[i].rd] = 1'b1;
            end
        end
        busy_regs[0] = 1'b0;
    end

    assign retire_slot = slots[LATENCY-1];

endmodule

// File: rtl/mul_issue_unit.sv
// rtl/mul_issue_unit.sv - issues multiplies to a pipelined multiplier with RAW/WAW stalls and tracks writeback
module mul_issue_unit
    import instruction_pkg::*;
#(
    parameter int MUL_LATENCY = constants_pkg::MUL_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    mul_issue_unit_if.slave  bus
);

    logic        hazard;
    logic        issue;
    mul_slot_t   retire_slot;
    logic [31:0] busy;

    // a register retiring this cycle is still busy, so a dependent op waits one more cycle
    assign hazard = reg_hit(bus.inst_in.src_reg_1, busy)
                 || reg_hit(bus.inst_in.src_reg_2, busy)
                 || reg_hit(bus.inst_in.dst_reg,   busy);

    assign bus.in_ready    = rst && !bus.flush && !hazard;
    assign issue           = bus.in_valid && bus.in_ready;
    assign bus.mul_issue   = issue;
    assign bus.inst_mul_in = bus.inst_in;

    assign bus.wb_valid  = rst && !bus.flush && retire_slot.valid && (retire_slot.rd != 5'd0);
    assign bus.wb_rd     = retire_slot.rd;
    assign bus.wb_data   = rst ? bus.inst_mul_out.dst_reg_data : '0;
    assign bus.busy_regs = busy;

    mul_scoreboard #(
        .LATENCY (MUL_LATENCY)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue       (issue),
        .issue_rd    (bus.inst_in.dst_reg),
        .flush       (bus.flush),
        .retire_slot (retire_slot),
        .busy_regs   (busy)
    );

endmodule

// File: tb/tb_mul_issue_unit.sv
// tb/tb_mul_issue_unit.sv - directed self-checking bench for mul_issue_unit
module tb_mul_issue_unit;

    import instruction_pkg::*;

    typedef struct {
        logic        v;
        logic [4:0]  s1, s2, rd;
        logic [31:0] a, b;
        logic        rdy, iss, wbv;
        logic [4:0]  wrd;
        logic [31:0] wdat, busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] mpipe [5];
    vec_t        vt [25];

    mul_issue_unit_if bus ();

    mul_issue_unit #(
        .MUL_LATENCY (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 5; i++) mpipe[i] = '0;
    end

    // reference 5-stage multiplier standing in for pipelined_multiplier
    always @(posedge clk) begin
        for (int i = 4; i > 0; i--) mpipe[i] <= mpipe[i-1];
        mpipe[0] <= bus.mul_issue ? bus.inst_mul_in.src_data_1 * bus.inst_mul_in.src_data_2 : 32'd0;
    end

    always_comb begin
        bus.inst_mul_out              = '0;
        bus.inst_mul_out.dst_reg_data = mpipe[4];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input logic fl);
        bus.in_valid           = v;
        bus.inst_in            = '0;
        bus.inst_in.src_reg_1  = s1;
        bus.inst_in.src_reg_2  = s2;
        bus.inst_in.dst_reg    = rd;
        bus.inst_in.src_data_1 = a;
        bus.inst_in.src_data_2 = b;
        bus.flush              = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] rd,
                                input logic [31:0] a, input logic [31:0] b, input logic rdy, input logic iss,
                                input logic wbv, input logic [4:0] wrd, input logic [31:0] wdat,
                                input logic [31:0] busy);
        vec_t r;
        r.v = v; r.s1 = s1; r.s2 = s2; r.rd = rd; r.a = a; r.b = b;
        r.rdy = rdy; r.iss = iss; r.wbv = wbv; r.wrd = wrd; r.wdat = wdat; r.busy = busy;
        return r;
    endfunction

    initial begin
        // single issue of 3*7 to x5, then x1..x5 back to back, hazards, then an x0 issue
        vt[0]  = mk(1, 1, 2, 5, 3, 7,  1, 1, 0, 0, 0,  32'h00);
        vt[1]  = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  32'h20);
        vt[2]  = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  32'h20);
        vt[3]  = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  32'h20);
        vt[4]  = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  32'h20);
        vt[5]  = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 5, 21, 32'h20);
        vt[6]  = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  32'h00);
        vt[7]  = mk(1, 10, 11, 1, 1, 3, 1, 1, 0, 0, 0, 32'h00);
        vt[8]  = mk(1, 10, 11, 2, 2, 3, 1, 1, 0, 0, 0, 32'h02);
        vt[9]  = mk(1, 10, 11, 3, 3, 3, 1, 1, 0, 0, 0, 32'h06);
        vt[10] = mk(1, 10, 11, 4, 4, 3, 1, 1, 0, 0, 0, 32'h0E);
        vt[11] = mk(1, 10, 11, 5, 5, 3, 1, 1, 0, 0, 0, 32'h1E);
        vt[12] = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 3,  32'h3E);
        vt[13] = mk(1, 0, 3, 9, 0, 0,  0, 0, 1, 2, 6,  32'h3C);
        vt[14] = mk(1, 0, 0, 4, 0, 0,  0, 0, 1, 3, 9,  32'h38);
        vt[15] = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 4, 12, 32'h30);
        vt[16] = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 5, 15, 32'h20);
        vt[17] = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  32'h00);
        vt[18] = mk(1, 0, 0, 0, 4, 4,  1, 1, 0, 0, 0,  32'h00);
        for (int i = 19; i < 25; i++) vt[i] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h00);

        drive(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("rst_mul_issue", {31'd0, bus.mul_issue}, 32'd0);
        chk("rst_wb_valid",  {31'd0, bus.wb_valid},  32'd0);
        chk("rst_wb_rd",     {27'd0, bus.wb_rd},     32'd0);
        chk("rst_wb_data",   bus.wb_data,            32'd0);
        chk("rst_busy",      bus.busy_regs,          32'd0);

        next_cycle();
        rst = 1'b1;
        idle();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_busy",     bus.busy_regs,          32'd0);
            chk("idle_in_ready", {31'd0, bus.in_ready},  32'd1);
            chk("idle_wb_valid", {31'd0, bus.wb_valid},  32'd0);
            next_cycle();
        end

        for (int i = 0; i < 25; i++) begin
            drive(vt[i].v, vt[i].s1, vt[i].s2, vt[i].rd, vt[i].a, vt[i].b, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i),  {31'd0, bus.in_ready},  {31'd0, vt[i].rdy});
            chk($sformatf("vec%0d_mul_issue", i), {31'd0, bus.mul_issue}, {31'd0, vt[i].iss});
            chk($sformatf("vec%0d_wb_valid", i),  {31'd0, bus.wb_valid},  {31'd0, vt[i].wbv});
            chk($sformatf("vec%0d_busy", i),      bus.busy_regs,          vt[i].busy);
            if (vt[i].wbv) begin
                chk($sformatf("vec%0d_wb_rd", i),   {27'd0, bus.wb_rd}, {27'd0, vt[i].wrd});
                chk($sformatf("vec%0d_wb_data", i), bus.wb_data,        vt[i].wdat);
            end
            next_cycle();
        end

        // RAW stall: x5 in flight holds a reader of x5 until the cycle after retire
        drive(1'b1, 5'd1, 5'd2, 5'd5, 32'd6, 32'd7, 1'b0);
        @(negedge clk);
        chk("raw_first_issue", {31'd0, bus.mul_issue}, 32'd1);
        next_cycle();
        for (int k = 1; k <= 12; k++) begin
            if (k <= 6) drive(1'b1, 5'd5, 5'd0, 5'd6, 32'd2, 32'd2, 1'b0);
            else        idle();
            @(negedge clk);
            chk($sformatf("raw_k%0d_in_ready", k), {31'd0, bus.in_ready}, (k <= 5) ? 32'd0 : 32'd1);
            if (k <= 6) chk($sformatf("raw_k%0d_issue", k), {31'd0, bus.mul_issue}, (k == 6) ? 32'd1 : 32'd0);
            chk($sformatf("raw_k%0d_wb_valid", k), {31'd0, bus.wb_valid}, (k == 5 || k == 11) ? 32'd1 : 32'd0);
            if (k == 5) chk("raw_wb_data_42", bus.wb_data, 32'd42);
            if (k == 11) begin
                chk("raw_wb_rd_6",   {27'd0, bus.wb_rd}, 32'd6);
                chk("raw_wb_data_4", bus.wb_data,        32'd4);
            end
            next_cycle();
        end

        // flush two ops in flight
        drive(1'b1, 5'd0, 5'd0, 5'd7, 32'd2, 32'd2, 1'b0);
        @(negedge clk);
        chk("flush_issue7", {31'd0, bus.mul_issue}, 32'd1);
        next_cycle();
        drive(1'b1, 5'd0, 5'd0, 5'd8, 32'd3, 32'd3, 1'b0);
        @(negedge clk);
        chk("flush_issue8", {31'd0, bus.mul_issue}, 32'd1);
        next_cycle();
        drive(1'b1, 5'd0, 5'd0, 5'd9, 32'd1, 32'd1, 1'b1);
        @(negedge clk);
        chk("flush_in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("flush_mul_issue", {31'd0, bus.mul_issue}, 32'd0);
        chk("flush_busy_pre",  bus.busy_regs,          32'h180);
        next_cycle();
        idle();
        @(negedge clk);
        chk("flush_busy_post", bus.busy_regs, 32'd0);
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            @(negedge clk);
            chk("flush_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        end
        next_cycle();

        // flush landing on the retire cycle suppresses the writeback
        drive(1'b1, 5'd0, 5'd0, 5'd12, 32'd5, 32'd5, 1'b0);
        next_cycle();
        idle();
        repeat (4) next_cycle();
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_retire_busy",  bus.busy_regs,         32'h1000);
        chk("flush_retire_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        next_cycle();
        idle();

        // reset mid-operation
        drive(1'b1, 5'd0, 5'd0, 5'd3, 32'd9, 32'd9, 1'b0);
        next_cycle();
        idle();
        #1;
        chk("midrst_busy_pre", bus.busy_regs, 32'h8);
        rst = 1'b0;
        #1;
        chk("midrst_busy",     bus.busy_regs,          32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready},  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("midrst_no_wb",   {31'd0, bus.wb_valid}, 32'd0);
            chk("midrst_busy_after", bus.busy_regs,      32'd0);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_issue_unit.md
MUL_ISSUE_UNIT -- requirements
Module: mul_issue_unit

Interface
REQ-001 Parameter: MUL_LATENCY, default 5, cycles from issue to multiplier result; taken from constants_pkg.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream presents a decoded multiply instruction.
REQ-005 inst_in  input  inst_decoded_t  decoded instruction: src_reg_1, src_reg_2, dst_reg (5 b each), src_data_1, src_data_2 (ARCH_LEN each).
REQ-006 in_ready  output  1  unit accepts inst_in this cycle.
REQ-007 flush  input  1  squash all in-flight multiplies.
REQ-008 inst_mul_in  output  inst_decoded_t  instruction driven to pipelined_multiplier.
REQ-009 mul_issue  output  1  inst_mul_in is valid this cycle.
REQ-010 inst_mul_out  input  inst_decoded_t  result returned by pipelined_multiplier (dst_reg_data, ARCH_LEN).
REQ-011 wb_valid  output  1  register-file write request.
REQ-012 wb_rd  output  5  write destination register.
REQ-013 wb_data  output  ARCH_LEN  write data.
REQ-014 busy_regs  output  32  scoreboard; bit r=1 means register r has a multiply in flight.

Function
REQ-015 Issue occurs in cycle T iff in_valid && in_ready; inst_mul_in = inst_in and mul_issue=1 combinationally in T, otherwise mul_issue=0.
REQ-016 Tracker: shift register of MUL_LATENCY slots, each {valid, rd}; slot 0 loads {issue, inst_in.dst_reg} each cycle, slot k loads slot k-1.
REQ-017 Retire: when last slot valid (cycle T+MUL_LATENCY), wb_valid=1, wb_rd=slot rd, wb_data=inst_mul_out.dst_reg_data truncated to ARCH_LEN low bits.
REQ-018 busy_regs bit r = OR over all valid slots with rd==r, excluding r=0; bit 0 always 0.
REQ-019 in_ready=0 when inst_in.src_reg_1, src_reg_2 or dst_reg (nonzero) hits busy_regs (RAW and WAW stall); retiring slot still counts as busy in its retire cycle.
REQ-020 in_ready=0 when flush=1; otherwise in_ready=1 absent hazard.
REQ-021 dst_reg==0: instruction issues, tracked with valid=1, but wb_valid stays 0 at retire.
REQ-022 flush: at next posedge all slot valid bits clear; wb_valid forced 0 in the flush cycle; no issue in the flush cycle.
REQ-023 Throughput: one issue per cycle with no hazards; up to MUL_LATENCY ops in flight.
REQ-024 Stalled instruction is held by upstream; unit keeps no copy of unaccepted inst_in.

Reset
REQ-025 rst low clears all slot valid bits and rd fields asynchronously.
REQ-026 During reset: mul_issue=0, wb_valid=0, wb_rd=0, wb_data=0, busy_regs=0, in_ready=0.
REQ-027 Reset asserted mid-operation discards all in-flight ops; no writeback follows reset release.

Structure
REQ-028 MUL_LATENCY, ARCH_LEN in constants_pkg; inst_decoded_t and a tracker slot typedef (mul_slot_t {valid, rd}) in instruction_pkg.
REQ-029 One sub-module, mul_scoreboard, holds tracker and busy_regs; hazard and issue logic in top.
REQ-030 Top instantiates no multiplier; pipelined_multiplier is connected alongside at the parent level.

Verification
REQ-031 Reset release, idle: busy_regs=0, in_ready=1, wb_valid=0 for 10 cycles.
REQ-032 Issue mul rd=5, 3*7 at T -> busy_regs[5]=1 T+1..T+5; wb_valid=1, wb_rd=5, wb_data=21 at T+5 only.
REQ-033 Issue rd=5 at T, then in_valid with src_reg_1=5 -> in_ready=0 through T+5, issues at T+6.
REQ-034 Back-to-back rd=1..5 at T..T+4 -> wb at T+5..T+9 in order, in_ready=1 throughout.
REQ-035 Issue rd=7 and rd=8, flush at T+2 -> no wb_valid ever, busy_regs=0 at T+3.
REQ-036 Issue rd=0 at T -> mul_issue=1 at T, wb_valid=0 at T+5, busy_regs[0]=0 throughout.
